// File: rtl/cpu_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_seq_pkg
// Shared definitions for the multi-cycle CPU control sequencer:
//   - seq_state_e : FSM state encoding (also exported on the debug port)
//   - op_class_e  : instruction class codes supplied by the decoder
//   - TIMEOUT_DEFAULT : default memory-wait watchdog limit
//   - isMemWait() : true for the states that wait on mem_ready
// ---------------------------------------------------------------------------
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_HALT  = 2'b11
  } op_class_e;

  localparam int TIMEOUT_DEFAULT = 16;

  // FETCH and MEM are the only states that hold a memory request open and
  // therefore the only ones the watchdog counts in.
  function automatic logic isMemWait(seq_state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
// Bundles the sequencer's decoder/memory/datapath-facing signals.
//   start      : begin execution from IDLE
//   op_class   : instruction class from the decoder (sampled in DECODE)
//   mem_ready  : memory completes the current request this cycle
//   mem_req    : memory request (FETCH, MEM)
//   mem_we     : memory write (MEM of a STORE)
//   ir_we      : IR load enable (FETCH with mem_ready)
//   pc_we      : PC increment enable (same cycle as ir_we)
//   reg_we     : register-file write enable (WB)
//   busy       : executing (not IDLE/HALT/ERR)
//   halted     : in HALT
//   err        : in ERR (watchdog trap)
//   state      : current state encoding for debug
// Modports: slave is the sequencer side, master is the environment side.
// ---------------------------------------------------------------------------
interface cpu_sequencer_if;

  logic       start;
  logic [1:0] op_class;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       ir_we;
  logic       pc_we;
  logic       reg_we;
  logic       busy;
  logic       halted;
  logic       err;
  logic [2:0] state;

  modport master (
    output start,
    output op_class,
    output mem_ready,
    input  mem_req,
    input  mem_we,
    input  ir_we,
    input  pc_we,
    input  reg_we,
    input  busy,
    input  halted,
    input  err,
    input  state
  );

  modport slave (
    input  start,
    input  op_class,
    input  mem_ready,
    output mem_req,
    output mem_we,
    output ir_we,
    output pc_we,
    output reg_we,
    output busy,
    output halted,
    output err,
    output state
  );

endinterface

// File: rtl/cpu_sequencer_wait_counter.sv
// ---------------------------------------------------------------------------
// seq_wait_counter
// Memory-wait watchdog counter for the sequencer. Counts consecutive cycles
// the sequencer spends waiting on memory and flags the last allowed one.
// Ports:
//   CLK    : system clock
//   RST_N  : synchronous active-low reset, clears the count
//   clr_i  : clear the count to zero (wins over inc_i)
//   inc_i  : advance the count by one, saturating at TIMEOUT-1
//   tc_o   : terminal count, high while the count equals TIMEOUT-1
// Parameters:
//   TIMEOUT : number of wait cycles tolerated (2..255)
//   CNT_W   : counter width, derived from TIMEOUT
// ---------------------------------------------------------------------------
module seq_wait_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             atLast;

  assign atLast = (count_q == LAST_COUNT);

  // Next count: a clear always wins, otherwise step up by one but hold at
  // the terminal value so a long stall can never wrap back to zero and
  // hide a timeout.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !atLast) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = atLast;

endmodule

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control sequencer for the CPU datapath. Steps each
// instruction through FETCH / DECODE / EXEC / MEM / WB, drives the IR, PC
// and register-file load enables plus the memory request handshake, and
// traps to ERR if memory stalls too long in FETCH or MEM.
// Zero-wait latency: ALU 4 cycles, LOAD 5, STORE 4; each wait adds one.
// Ports:
//   CLK   : system clock, all state updates on the rising edge
//   RST_N : synchronous active-low reset (to IDLE, watchdog cleared)
//   bus   : cpu_sequencer_if.slave, handshake and enable signals
// Parameters:
//   TIMEOUT : max consecutive wait cycles in FETCH or MEM (2..255)
// ---------------------------------------------------------------------------
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  cpu_sequencer_if.slave        bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  seq_state_e state_q;
  seq_state_e state_d;
  op_class_e  opClass_q;
  op_class_e  opClass_d;

  logic waitInc;
  logic waitClr;
  logic waitTc;

  logic memReq;
  logic memWe;
  logic irWe;
  logic pcWe;
  logic regWe;
  logic busyOut;
  logic haltedOut;
  logic errOut;

  // The watchdog only advances while a memory request is outstanding and
  // unanswered. Every other cycle clears it, which covers clearing on
  // entry to FETCH or MEM, including the direct MEM -> FETCH hop of a
  // STORE (the completing cycle has mem_ready high, so it clears).
  assign waitInc = isMemWait(state_q) && !bus.mem_ready;
  assign waitClr = !waitInc;

  seq_wait_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_counter (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr_i (waitClr),
    .inc_i (waitInc),
    .tc_o  (waitTc)
  );

  // State register plus the latched instruction class. Reset aborts any
  // instruction in flight and returns to IDLE.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      opClass_q <= OP_ALU;
    end else begin
      state_q   <= state_d;
      opClass_q <= opClass_d;
    end
  end

  // Next-state logic. op_class is only looked at live in DECODE and is
  // captured there; EXEC and MEM steer from the captured copy so the
  // decoder may move on. In the wait states mem_ready is checked before
  // the watchdog, so a response on the last allowed cycle still proceeds.
  always_comb begin
    state_d   = state_q;
    opClass_d = opClass_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (waitTc) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        opClass_d = op_class_e'(bus.op_class);
        if (op_class_e'(bus.op_class) == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (opClass_q == OP_ALU) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          if (opClass_q == OP_LOAD) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (waitTc) begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode. Everything is Moore from the state register except the
  // IR/PC enables, which fire only on the FETCH cycle memory returns the
  // instruction word.
  always_comb begin
    memReq    = 1'b0;
    memWe     = 1'b0;
    irWe      = 1'b0;
    pcWe      = 1'b0;
    regWe     = 1'b0;
    busyOut   = 1'b0;
    haltedOut = 1'b0;
    errOut    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memReq  = 1'b1;
        irWe    = bus.mem_ready;
        pcWe    = bus.mem_ready;
        busyOut = 1'b1;
      end
      ST_DECODE: begin
        busyOut = 1'b1;
      end
      ST_EXEC: begin
        busyOut = 1'b1;
      end
      ST_MEM: begin
        memReq  = 1'b1;
        memWe   = (opClass_q == OP_STORE);
        busyOut = 1'b1;
      end
      ST_WB: begin
        regWe   = 1'b1;
        busyOut = 1'b1;
      end
      ST_HALT: begin
        haltedOut = 1'b1;
      end
      ST_ERR: begin
        errOut = 1'b1;
      end
      default: begin
        busyOut = 1'b0;
      end
    endcase
  end

  assign bus.mem_req = memReq;
  assign bus.mem_we  = memWe;
  assign bus.ir_we   = irWe;
  assign bus.pc_we   = pcWe;
  assign bus.reg_we  = regWe;
  assign bus.busy    = busyOut;
  assign bus.halted  = haltedOut;
  assign bus.err     = errOut;
  assign bus.state   = state_q;

endmodule
